alu_share_ctrl: RTL and testbench
=================================

// Module: alu_share_ctrl
// PURPOSE
//  Time-shares one W-bit ALU (ADD/SUB/AND/OR/XOR + unsigned compare) among NREQ requesters.
//  Round-robin arbitration; valid/ready request per requester; one shared response channel
//  tagged with the requester id. Sits between lab-level stimulus/FSM blocks and the ALU datapath.
// PARAMETERS
//  NREQ  4  number of requesters (2..8)
//  W     4  operand width; result is W+1 bits
// PORTS
//  clk        in   1          clock, all state on rising edge
//  rst        in   1          asynchronous, active-high reset
//  req_valid  in   NREQ       requester i has an operation pending
//  req_ready  out  NREQ       one-hot accept strobe; transfer when req_valid[i]&req_ready[i]
//  req_op     in   3*NREQ     opcode of requester i at [3i+2:3i]
//  req_a      in   W*NREQ     operand A of requester i at [Wi+W-1:Wi]
//  req_b      in   W*NREQ     operand B of requester i, same packing
//  rsp_valid  out  1          response available
//  rsp_ready  in   1          consumer accepts response
//  rsp_id     out  3          index of requester that owns the response
//  rsp_data   out  W+1        result
//  rsp_flags  out  3          {gt,eq,lt} of A vs B, unsigned
//  rsp_err    out  1          opcode was illegal
//  busy       out  1          high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, all registered outputs 0 (rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_err).
//  FSM  IDLE -> EXEC when any req_valid; EXEC -> RESP always; RESP -> IDLE when rsp_ready.
//  IDLE: grant = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NREQ.
//   req_ready[grant]=1, combinational, IDLE only; all other cycles req_ready=0.
//   On accept: latch op/a/b/id; rr_ptr <= (grant+1) mod NREQ.
//  EXEC: alu_core evaluates latched operands; rsp_* registered at end of cycle.
//  RESP: rsp_valid=1. rsp_id/data/flags/err hold stable until rsp_ready sampled high.
//   rsp_valid falls the cycle after handshake. No new grant is issued in RESP.
//  Latency: accept edge T -> rsp_valid high from T+2. Max throughput 1 op / 3 cycles.
//  Opcodes: 0 ADD  {0,a}+{0,b}, bit W = carry.   1 SUB  ({0,a}-{0,b}) mod 2^(W+1), bit W = borrow.
//   2 AND / 3 OR / 4 XOR zero-extended to W+1.   5..7 illegal: rsp_data=0, rsp_err=1.
//   Flags are computed for every opcode, including illegal ones.
//  Requests: a requester whose req_valid drops before grant is simply skipped.
//   Operands are sampled only at the accept edge.
//  Reset mid-operation: in-flight op discarded, no response produced, rr_ptr returns to 0.
// STRUCTURE
//  Package alu_pkg: opcode localparams OP_ADD..OP_XOR, OP_W=3, FSM state encodings
//   S_IDLE/S_EXEC/S_RESP.
//  Sub-module alu_core (combinational). Ports: op, a, b -> y[W:0], gt, eq, lt, err.
//   Used as the sole ALU instance.
//  Arbiter: rotate-priority-encode logic stays inline in this module.
// TESTING
//  1. req0 ADD a=4'hD b=4'h7 -> req_ready[0] in cycle T; rsp at T+2.
//     id=0, data=5'b10100, flags=100, err=0.
//  2. req1 SUB a=4'h7 b=4'hD -> data=5'b11010 (borrow set), flags=001.
//     Then a=b=4'h5 -> data=0, flags=010.
//  3. req0 and req2 valid from reset, held:
//     -> grants 0,2,0,2 in that order (rr_ptr after 0 is 1, skips to 2).
//  4. rsp_ready held low 5 cycles in RESP:
//     -> rsp_* stable, busy=1, all req_ready=0; handshake then -> IDLE next cycle.
//  5. op=3'd6, a=4'h3 b=4'h3 -> data=0, err=1, flags=010.
//     Next legal op on same requester -> err=0.
//  6. Assert rst during EXEC after granting req3 -> rsp_valid never rises.
//     After release, req1 and req3 both valid -> req1 granted first.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and FSM states shared by the ALU sharing controller
package alu_pkg;
  localparam int OP_W = 3;
  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational W-bit ALU with carry/borrow result bit and unsigned compare flags
module alu_core import alu_pkg::*; #(
  parameter int W = 4
) (
  input  logic [OP_W-1:0] op,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  output logic [W:0]      y,
  output logic            gt,
  output logic            eq,
  output logic            lt,
  output logic            err
);
  assign y = op == OP_ADD ? {1'b0, a} + {1'b0, b} :
             op == OP_SUB ? {1'b0, a} - {1'b0, b} :
             op == OP_AND ? {1'b0, a & b} :
             op == OP_OR  ? {1'b0, a | b} :
             op == OP_XOR ? {1'b0, a ^ b} : '0;
  assign gt  = a > b;
  assign eq  = a == b;
  assign lt  = a < b;
  assign err = op > OP_XOR;
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin time-sharing of one ALU among NREQ valid/ready requesters
module alu_share_ctrl import alu_pkg::*; #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [OP_W*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0]    req_a,
  input  logic [W*NREQ-1:0]    req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2:0]           rsp_id,
  output logic [W:0]           rsp_data,
  output logic [2:0]           rsp_flags,
  output logic                 rsp_err,
  output logic                 busy
);
  state_t state;
  logic [2:0] rr_ptr, off, gnt, id_q;
  logic [3:0] sum;
  logic [NREQ-1:0] rot;
  logic [OP_W-1:0] op_q;
  logic [W-1:0] a_q, b_q;
  logic [W:0] y;
  logic gt, eq, lt, err;
  // rotate so rr_ptr sits at bit 0, pick the lowest set bit, then rotate back
  assign rot = NREQ'({req_valid, req_valid} >> rr_ptr);
  always_comb begin
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) if (rot[i]) off = 3'(i);
  end
  assign sum = {1'b0, rr_ptr} + {1'b0, off};
  assign gnt = sum >= 4'(NREQ) ? 3'(sum - 4'(NREQ)) : sum[2:0];
  assign req_ready = state == S_IDLE ? req_valid & (NREQ'(1) << gnt) : '0;
  assign busy = state != S_IDLE;
  alu_core #(.W(W)) u_alu (.op(op_q), .a(a_q), .b(b_q), .y(y), .gt(gt), .eq(eq), .lt(lt), .err(err));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (|req_valid) begin
          state  <= S_EXEC;
          op_q   <= req_op[OP_W*gnt +: OP_W];
          a_q    <= req_a[W*gnt +: W];
          b_q    <= req_b[W*gnt +: W];
          id_q   <= gnt;
          rr_ptr <= gnt == 3'(NREQ - 1) ? '0 : gnt + 3'd1;
        end
        S_EXEC: begin
          state     <= S_RESP;
          rsp_valid <= 1'b1;
          rsp_id    <= id_q;
          rsp_data  <= y;
          rsp_flags <= {gt, eq, lt};
          rsp_err   <= err;
        end
        S_RESP: if (rsp_ready) begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: randomized self-checking bench with an arithmetic reference model
module tb_alu_share_ctrl;
  localparam int NREQ = 4;
  localparam int W = 4;
  logic clk = 0;
  logic rst = 1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready;
  logic [3*NREQ-1:0] req_op = '0;
  logic [W*NREQ-1:0] req_a = '0;
  logic [W*NREQ-1:0] req_b = '0;
  logic rsp_valid, rsp_ready = 0;
  logic [2:0] rsp_id;
  logic [W:0] rsp_data;
  logic [2:0] rsp_flags;
  logic rsp_err, busy;
  int checks = 0;
  int errors = 0;
  int ptr = 0;
  int rop[NREQ], ra[NREQ], rb[NREQ];

  alu_share_ctrl #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // expected {data, gt, eq, lt, err}
  function automatic logic [8:0] model(int op, int a, int b);
    int d;
    d = op == 0 ? (a + b) % 32 : op == 1 ? (a - b + 32) % 32 :
        op == 2 ? (a & b) : op == 3 ? (a | b) : op == 4 ? (a ^ b) : 0;
    return {5'(d), a > b, a == b, a < b, op > 4};
  endfunction

  function automatic int exp_grant();
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic set_req(int r, int op, int a, int b);
    rop[r] = op; ra[r] = a; rb[r] = b;
    req_op[3*r +: 3] = 3'(op);
    req_a[W*r +: W] = W'(a);
    req_b[W*r +: W] = W'(b);
    req_valid[r] = 1'b1;
  endtask

  task automatic wait_grant(output int g);
    g = -1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (|req_ready) begin
        g = $clog2(req_ready);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_op(input int r, input int op, input int a, input int b, output int g,
                        output logic v1, output logic v2, output logic [2:0] id, output logic [8:0] got);
    @(negedge clk);
    set_req(r, op, a, b);
    wait_grant(g);
    v1 = 0; v2 = 0; id = 0; got = 0;
    if (g < 0) begin
      req_valid[r] = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid[r] = 1'b0;
    v1 = rsp_valid;
    @(negedge clk);
    v2 = rsp_valid; id = rsp_id; got = {rsp_data, rsp_flags, rsp_err};
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_err, busy, req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b id=%0d data=%h flags=%b err=%b busy=%b ready=%b, want all 0",
               rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_err, busy, req_ready);
    end
    rst = 0;
    ptr = 0;
  endtask

  task automatic test_add();
    int g; logic v1, v2; logic [2:0] id; logic [8:0] got;
    run_op(0, 0, 'hD, 'h7, g, v1, v2, id, got);
    ptr = (g + 1) % NREQ;
    checks++;
    if (g !== 0 || v1 !== 0 || v2 !== 1) begin
      errors++;
      $display("FAIL add_latency: grant=%0d v@T+1=%b v@T+2=%b, want grant=0 v=0 then 1", g, v1, v2);
    end
    checks++;
    if (id !== 3'd0 || got !== 9'b10100_100_0 || got !== model(0, 'hD, 'h7)) begin
      errors++;
      $display("FAIL add_result: id=%0d rsp=%b, want id=0 rsp=%b", id, got, 9'b10100_100_0);
    end
    checks++;
    if (busy !== 0 || rsp_valid !== 0) begin
      errors++;
      $display("FAIL add_return_idle: busy=%b valid=%b, want 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_sub();
    int g; logic v1, v2; logic [2:0] id; logic [8:0] got;
    run_op(1, 1, 'h7, 'hD, g, v1, v2, id, got);
    ptr = (g + 1) % NREQ;
    checks++;
    if (g !== 1 || v2 !== 1 || id !== 3'd1 || got !== 9'b11010_001_0) begin
      errors++;
      $display("FAIL sub_borrow: grant=%0d v=%b id=%0d rsp=%b, want grant=1 id=1 rsp=%b", g, v2, id, got, 9'b11010_001_0);
    end
    run_op(1, 1, 'h5, 'h5, g, v1, v2, id, got);
    ptr = (g + 1) % NREQ;
    checks++;
    if (g !== 1 || v2 !== 1 || got !== 9'b00000_010_0) begin
      errors++;
      $display("FAIL sub_equal: grant=%0d v=%b rsp=%b, want grant=1 rsp=%b", g, v2, got, 9'b00000_010_0);
    end
  endtask

  task automatic test_arb();
    int g, eg;
    int want[4] = '{0, 2, 0, 2};
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    ptr = 0;
    set_req(0, $urandom_range(0, 4), $urandom_range(0, 15), $urandom_range(0, 15));
    set_req(2, $urandom_range(0, 4), $urandom_range(0, 15), $urandom_range(0, 15));
    for (int n = 0; n < 4; n++) begin
      wait_grant(g);
      eg = exp_grant();
      checks++;
      if (g !== eg || g !== want[n]) begin
        errors++;
        $display("FAIL arb_order[%0d]: grant=%0d, want %0d", n, g, want[n]);
      end
      if (g >= 0) ptr = (g + 1) % NREQ;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (g < 0 || rsp_valid !== 1 || rsp_id !== 3'(g) ||
          {rsp_data, rsp_flags, rsp_err} !== model(rop[g], ra[g], rb[g])) begin
        errors++;
        $display("FAIL arb_rsp[%0d]: valid=%b id=%0d rsp=%b, want id=%0d", n, rsp_valid, rsp_id,
                 {rsp_data, rsp_flags, rsp_err}, g);
      end
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
    end
    req_valid = '0;
  endtask

  task automatic test_stall();
    int g; logic [8:0] exp; bit bad = 0;
    @(negedge clk);
    set_req(3, $urandom_range(0, 4), $urandom_range(0, 15), $urandom_range(0, 15));
    exp = model(rop[3], ra[3], rb[3]);
    wait_grant(g);
    ptr = (g + 1) % NREQ;
    @(negedge clk);
    req_valid[3] = 0;
    req_valid[1] = 1;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      if (rsp_valid !== 1 || busy !== 1 || req_ready !== '0 || rsp_id !== 3'd3 ||
          {rsp_data, rsp_flags, rsp_err} !== exp) bad = 1;
      @(negedge clk);
    end
    checks++;
    if (g !== 3 || bad) begin
      errors++;
      $display("FAIL stall_hold: grant=%0d valid=%b busy=%b ready=%b id=%0d rsp=%b, want id=3 rsp=%b",
               g, rsp_valid, busy, req_ready, rsp_id, {rsp_data, rsp_flags, rsp_err}, exp);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    #1;
    checks++;
    if (rsp_valid !== 0 || busy !== 0 || req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL stall_release: valid=%b busy=%b ready=%b, want 0 0 0010", rsp_valid, busy, req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_illegal();
    int g; logic v1, v2; logic [2:0] id; logic [8:0] got; int op, a, b;
    run_op(2, 6, 'h3, 'h3, g, v1, v2, id, got);
    ptr = (g + 1) % NREQ;
    checks++;
    if (g !== 2 || v2 !== 1 || got !== 9'b00000_010_1) begin
      errors++;
      $display("FAIL illegal_op: grant=%0d rsp=%b, want grant=2 rsp=%b", g, got, 9'b00000_010_1);
    end
    op = $urandom_range(0, 4); a = $urandom_range(0, 15); b = $urandom_range(0, 15);
    run_op(2, op, a, b, g, v1, v2, id, got);
    ptr = (g + 1) % NREQ;
    checks++;
    if (g !== 2 || v2 !== 1 || got !== model(op, a, b)) begin
      errors++;
      $display("FAIL legal_after_illegal: rsp=%b, want %b", got, model(op, a, b));
    end
  endtask

  task automatic test_rst_mid();
    int g; bit seen = 0;
    @(negedge clk);
    set_req(3, 0, 'h9, 'h9);
    wait_grant(g);
    @(negedge clk);
    req_valid = '0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    ptr = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rsp_valid !== 0 || busy !== 0) seen = 1;
    end
    checks++;
    if (g !== 3 || seen) begin
      errors++;
      $display("FAIL reset_mid_exec: grant=%0d response_or_busy_seen=%0d, want grant=3 seen=0", g, seen);
    end
    set_req(1, 2, 'hC, 'hA);
    set_req(3, 3, 'h1, 'h2);
    wait_grant(g);
    checks++;
    if (g !== 1 || g !== exp_grant()) begin
      errors++;
      $display("FAIL reset_ptr: grant=%0d, want 1", g);
    end
    ptr = 2;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1 || rsp_id !== 3'd1 || {rsp_data, rsp_flags, rsp_err} !== model(2, 'hC, 'hA)) begin
      errors++;
      $display("FAIL reset_then_op: valid=%b id=%0d rsp=%b, want id=1 rsp=%b", rsp_valid, rsp_id,
               {rsp_data, rsp_flags, rsp_err}, model(2, 'hC, 'hA));
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic test_random();
    int g, eg; logic [3:0] m;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      m = 4'($urandom_range(1, 15));
      for (int r = 0; r < NREQ; r++)
        if (m[r]) set_req(r, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
      eg = exp_grant();
      wait_grant(g);
      checks++;
      if (g !== eg) begin
        errors++;
        $display("FAIL rand_grant[%0d]: mask=%b grant=%0d, want %0d", n, m, g, eg);
      end
      ptr = (eg + 1) % NREQ;
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1 || rsp_id !== 3'(eg) ||
          {rsp_data, rsp_flags, rsp_err} !== model(rop[eg], ra[eg], rb[eg])) begin
        errors++;
        $display("FAIL rand_rsp[%0d]: valid=%b id=%0d rsp=%b, want id=%0d rsp=%b", n, rsp_valid, rsp_id,
                 {rsp_data, rsp_flags, rsp_err}, eg, model(rop[eg], ra[eg], rb[eg]));
      end
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_arb();
    test_stall();
    test_illegal();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
